imem_rom: RTL and testbench
===========================

IMEM_ROM -- requirements
Module: imem_rom

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 7, byte-address width.
REQ-002 The block SHALL expose parameter DEPTH, default 32, number of 32-bit words stored; DEPTH*4 <= 2**ADDR_W.
REQ-003 The block SHALL expose parameter WAIT, default 0, range 0..3, extra wait cycles per read.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  1  read request, qualified by ready.
REQ-008 addr  input  ADDR_W  byte address of the instruction word.
REQ-009 ready  output  1  block can accept a request this cycle.
REQ-010 rvalid  output  1  response valid.
REQ-011 rready  input  1  consumer accepts the response.
REQ-012 rdata  output  32  instruction word, little-endian: byte addr+3 in [31:24], byte addr in [7:0].
REQ-013 err  output  1  response fault flag, valid with rvalid.
REQ-014 load_en  input  1  program-load write strobe.
REQ-015 load_addr  input  ADDR_W  byte address of the word to load; bits [1:0] are ignored.
REQ-016 load_data  input  32  word to load.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and RESP; ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted when req=1 and ready=1 at a clock edge; addr SHALL be sampled in that cycle only.
REQ-019 Accept transitions: WAIT=0 -> RESP next cycle; otherwise -> BUSY, with the wait counter loaded to WAIT-1.
REQ-020 In BUSY the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the cycle after the counter reaches 0.
REQ-021 Latency SHALL be exactly WAIT+1 cycles from the accept edge to the first cycle with rvalid=1.
REQ-022 In RESP, rvalid=1, and rdata and err SHALL remain stable until a cycle with rready=1; that edge SHALL return the FSM to IDLE.
REQ-023 If rready=1 in the first RESP cycle, rvalid SHALL be high for exactly one cycle.
REQ-024 There SHALL be no back-to-back acceptance; at least one IDLE cycle separates responses.
REQ-025 The read word SHALL be the memory content at the accept edge.
REQ-026 A load to the same word in the accept cycle SHALL NOT affect that read (read-before-write).
REQ-027 Misalignment: if addr[1:0] != 0, the response SHALL have err=1 and rdata=0.
REQ-028 Out of range: if addr >= DEPTH*4, the response SHALL have err=1 and rdata=0; this SHALL not wrap.
REQ-029 Otherwise the response SHALL have err=0 and rdata = word[addr[ADDR_W-1:2]].
REQ-030 When load_en=1 and load_addr < DEPTH*4, the edge SHALL write load_data to word load_addr[ADDR_W-1:2].
REQ-031 An out-of-range load SHALL be silently dropped.
REQ-032 Loads SHALL be accepted in any FSM state, including during reset.
REQ-033 req asserted while ready=0 SHALL be ignored and have no effect.
REQ-034 Memory contents SHALL be all zero at time zero.

Reset
REQ-035 While rst=1 at an edge: FSM -> IDLE, counter=0, rvalid=0, err=0, rdata=0.
REQ-036 The cycle after reset deasserts, ready SHALL be 1.
REQ-037 Reset SHALL NOT alter memory contents.
REQ-038 Reset during BUSY or RESP SHALL abort the in-flight read with no response produced.
REQ-039 req is ignored while rst=1.

Verification
REQ-040 WAIT=0: load word 1 = 0x00348093, then req addr=4 with rready=1 -> one cycle later rvalid=1, rdata=0x00348093, err=0; next cycle ready=1.
REQ-041 WAIT=3: req addr=0 -> rvalid first asserts 4 cycles after accept; with rready=0 for 5 cycles, rvalid and rdata stay stable; rready=1 -> IDLE.
REQ-042 req addr=6 -> err=1, rdata=0; req addr=128 with DEPTH=32 -> err=1, rdata=0; neither read wraps to word 0.
REQ-043 Same-cycle accept at addr=8 with load_addr=8, load_data=0xDEADBEEF, old content 0 -> response rdata=0; a following read -> 0xDEADBEEF.
REQ-044 Assert rst in the second BUSY cycle (WAIT=2) -> no rvalid appears; ready=1 after release; previously loaded words are intact.
REQ-045 Hold req=1 continuously with rready=1 -> accepts occur at most every WAIT+2 cycles, never while rvalid=1.

Source files
------------

// File: rtl/imem_rom.sv
// Instruction ROM with a program-load port; read word registered at accept, rvalid WAIT+1 cycles later.
// Response is held until rready; ready only while idle, so accepts never occur back-to-back.
module imem_rom #(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 32,
   parameter int WAIT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              ready,
   output logic              rvalid,
   input  logic              rready,
   output logic [31:0]       rdata,
   output logic              err,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
);
   localparam logic [1:0]  IDLE    = 2'd0;
   localparam logic [1:0]  BUSY    = 2'd1;
   localparam logic [1:0]  RESP    = 2'd2;
   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] LIMIT   = 32'(DEPTH * 4);
   localparam logic [1:0]  WAIT_M1 = (WAIT > 0) ? 2'(WAIT - 1) : 2'd0;

   logic [1:0]    state;
   logic [1:0]    cnt;
   logic [31:0]   mem [DEPTH] = '{default: '0};
   logic [IW-1:0] ridx;
   logic [IW-1:0] lidx;
   logic          req_bad;
   logic          ld_ok;
   logic          load_unused;

   assign ridx        = addr[IW+1:2];
   assign lidx        = load_addr[IW+1:2];
   assign load_unused = ^load_addr[1:0];
   // Range checks are done on the full byte address so out-of-range never aliases onto low words.
   assign req_bad     = (addr[1:0] != 2'b00) || (32'(addr) >= LIMIT);
   assign ld_ok       = load_en && (32'(load_addr) < LIMIT);
   assign ready       = (state == IDLE);
   assign rvalid      = (state == RESP);

   always_ff @(posedge clk) begin
      if (ld_ok)
         mem[lidx] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
         rdata <= 32'd0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  rdata <= req_bad ? 32'd0 : mem[ridx];
                  err   <= req_bad;
                  cnt   <= WAIT_M1;
                  state <= (WAIT == 0) ? RESP : BUSY;
               end
            end
            BUSY: begin
               if (cnt == 2'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 2'd1;
            end
            RESP: begin
               if (rready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_rom.sv
// Three ROM instances (WAIT 0/2/3) sharing clock, reset and load bus, checked against a word-array model.
module tb_imem_rom;
   localparam int NI = 3;
   localparam int WT [NI] = '{0, 2, 3};

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   logic        req    [NI];
   logic [7:0]  addr   [NI];
   logic        rready [NI];
   logic        ready  [NI];
   logic        rvalid [NI];
   logic [31:0] rdata  [NI];
   logic        err    [NI];

   logic [31:0] mdl [32];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      imem_rom #(.ADDR_W(8), .DEPTH(32), .WAIT(WT[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req       (req[g]),
         .addr      (addr[g]),
         .ready     (ready[g]),
         .rvalid    (rvalid[g]),
         .rready    (rready[g]),
         .rdata     (rdata[g]),
         .err       (err[g]),
         .load_en   (load_en),
         .load_addr (load_addr),
         .load_data (load_data)
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [7:0] la, input logic [31:0] ld);
      load_en = 1'b1; load_addr = la; load_data = ld;
      @(negedge clk);
      load_en = 1'b0;
      if (la < 8'd128) mdl[la[6:2]] = ld;
   endtask

   // Issue one read on instance i, hold the response for 'hold' cycles, optionally load in the accept cycle.
   task automatic do_read(input int i, input logic [7:0] a, input int hold,
                          input bit ld, input logic [7:0] la, input logic [31:0] ldat);
      logic [31:0] ed;
      logic        ee;
      int          k;
      ee = (a[1:0] != 2'b00) || (a >= 8'd128);
      ed = ee ? 32'd0 : mdl[a[6:2]];
      check($sformatf("ready_pre%0d", i), 32'(ready[i]), 32'd1);
      req[i] = 1'b1; addr[i] = a; rready[i] = 1'b0;
      if (ld) begin load_en = 1'b1; load_addr = la; load_data = ldat; end
      @(negedge clk);
      req[i] = 1'b0; addr[i] = 8'($urandom); load_en = 1'b0;
      if (ld && la < 8'd128) mdl[la[6:2]] = ldat;
      k = 1;
      while (!rvalid[i] && k < 12) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("lat%0d a=%0d", i, a), 32'(k), 32'(WT[i] + 1));
      check($sformatf("rdata%0d a=%0d", i, a), rdata[i], ed);
      check($sformatf("err%0d a=%0d", i, a), 32'(err[i]), 32'(ee));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check($sformatf("hold_vld%0d", i), 32'(rvalid[i]), 32'd1);
         check($sformatf("hold_dat%0d", i), rdata[i], ed);
      end
      rready[i] = 1'b1;
      @(negedge clk);
      rready[i] = 1'b0;
      check($sformatf("post_vld%0d", i), 32'(rvalid[i]), 32'd0);
      check($sformatf("post_rdy%0d", i), 32'(ready[i]), 32'd1);
   endtask

   initial begin
      int last;
      int k;
      for (int w = 0; w < 32; w++) mdl[w] = 32'd0;
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      for (int i = 0; i < NI; i++) begin
         req[i] = 1'b0; addr[i] = '0; rready[i] = 1'b0;
      end
      // req during reset must be ignored; a load during reset must land
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      do_load(8'd20, 32'hCAFE0005);
      req[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_rdy%0d", i), 32'(ready[i]), 32'd1);
         check($sformatf("rst_vld%0d", i), 32'(rvalid[i]), 32'd0);
         check($sformatf("rst_dat%0d", i), rdata[i], 32'd0);
         check($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      end

      do_load(8'd4, 32'h00348093);
      do_read(0, 8'd4, 0, 0, 8'd0, 32'd0);
      do_read(0, 8'd20, 0, 0, 8'd0, 32'd0);
      do_load(8'd0, 32'h11111111);
      do_read(2, 8'd0, 5, 0, 8'd0, 32'd0);
      do_read(0, 8'd6, 0, 0, 8'd0, 32'd0);
      do_read(0, 8'd128, 0, 0, 8'd0, 32'd0);
      do_read(1, 8'd132, 1, 0, 8'd0, 32'd0);
      do_load(8'd200, 32'h99999999);
      do_read(0, 8'd0, 0, 0, 8'd0, 32'd0);
      do_read(0, 8'd8, 0, 1, 8'd8, 32'hDEADBEEF);
      do_read(0, 8'd8, 0, 0, 8'd0, 32'd0);

      // abort a WAIT=2 read in its second BUSY cycle
      req[1] = 1'b1; addr[1] = 8'd4;
      @(negedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      load_en = 1'b1; load_addr = 8'd12; load_data = 32'h0BADF00D;
      @(negedge clk);
      rst = 1'b0; load_en = 1'b0; mdl[3] = 32'h0BADF00D;
      for (int c = 0; c < 6; c++) begin
         check("abort_vld", 32'(rvalid[1]), 32'd0);
         check("abort_rdy", 32'(ready[1]), 32'd1);
         @(negedge clk);
      end
      do_read(1, 8'd4, 0, 0, 8'd0, 32'd0);
      do_read(1, 8'd12, 0, 0, 8'd0, 32'd0);
      do_read(1, 8'd8, 0, 0, 8'd0, 32'd0);

      // continuous req with rready=1: accept spacing is WAIT+2, never with rvalid high
      for (int i = 0; i < NI; i++) begin
         last = -1;
         req[i] = 1'b1; addr[i] = 8'd4; rready[i] = 1'b1;
         for (int c = 0; c < 30; c++) begin
            check($sformatf("b2b%0d", i), 32'(ready[i] & rvalid[i]), 32'd0);
            if (rvalid[i]) check($sformatf("burst_dat%0d", i), rdata[i], mdl[1]);
            if (ready[i]) begin
               if (last >= 0) check($sformatf("gap%0d", i), 32'(c - last), 32'(WT[i] + 2));
               last = c;
            end
            @(negedge clk);
         end
         req[i] = 1'b0;
         k = 0;
         while (!ready[i] && k < 10) begin @(negedge clk); k++; end
         rready[i] = 1'b0;
         check($sformatf("drain%0d", i), 32'(ready[i]), 32'd1);
      end

      for (int t = 0; t < 80; t++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31) * 4) : 8'($urandom);
         if ($urandom_range(0, 2) == 0)
            do_load(8'($urandom), $urandom);
         else if ($urandom_range(0, 3) == 0)
            do_read(int'($urandom_range(0, NI - 1)), a, int'($urandom_range(0, 3)),
                    1, a, $urandom);
         else
            do_read(int'($urandom_range(0, NI - 1)), a, int'($urandom_range(0, 3)),
                    0, 8'd0, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
